// File: rtl/mmio_device_responder.sv
// mmio_device_responder
//   Memory-mapped peripheral front end with two CPU-visible registers:
//   a data register and a status/control register.
//   - A CPU write to the data register sends one word out on the TX
//     valid/ready port.
//   - Words arriving on the RX valid/ready port are queued in a small FIFO.
//     A CPU read of the data register pops the head of that FIFO.
//   - The status register reports FIFO and TX state, holds the two
//     interrupt enables and a sticky TX-overrun flag.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   mem_addr/wdata/we/re   CPU access, one-cycle strobes
//   mem_rdata/rvalid       registered read response, latency 1
//   mem_hit                combinational address decode
//   tx_data/valid/ready    outbound word to the peripheral
//   rx_data/valid/ready    inbound word from the peripheral
//   irq                    registered interrupt request
module mmio_device_responder #(
   parameter logic [31:0] DATA_ADDR   = 32'hFFFF8004,
   parameter logic [31:0] STATUS_ADDR = 32'hFFFF8000,
   parameter int unsigned RX_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [31:0] mem_rdata,
   output logic        mem_rvalid,
   output logic        mem_hit,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        irq
);

   localparam int unsigned PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RX_DEPTH + 1);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_SEND = 1'b1;

   logic          tx_state_q, tx_state_d;
   logic [31:0]   tx_data_q,  tx_data_d;
   logic          dropped_q,  dropped_d;
   logic          rx_ie_q,    rx_ie_d;
   logic          tx_ie_q,    tx_ie_d;
   logic [PW-1:0] wptr_q,     wptr_d;
   logic [PW-1:0] rptr_q,     rptr_d;
   logic [CW-1:0] count_q,    count_d;
   logic [31:0]   rdata_q,    rdata_d;
   logic          rvalid_q,   rvalid_d;
   logic          irq_q,      irq_d;

   logic [31:0]   fifo_q [RX_DEPTH];

   logic          hit_data, hit_stat;
   logic          wr_data, wr_stat, rd_data, rd_stat;
   logic          rx_full, rx_nonempty, tx_busy;
   logic          push, pop;
   logic [3:0]    count_ext;
   logic [31:0]   status_word;

   // Address decode; a write always wins over a simultaneous read strobe.
   assign hit_data = (mem_addr == DATA_ADDR);
   assign hit_stat = (mem_addr == STATUS_ADDR);
   assign mem_hit  = hit_data | hit_stat;

   assign wr_data = mem_we & hit_data;
   assign wr_stat = mem_we & hit_stat;
   assign rd_data = mem_re & ~mem_we & hit_data;
   assign rd_stat = mem_re & ~mem_we & hit_stat;

   assign rx_full     = (count_q == CW'(RX_DEPTH));
   assign rx_nonempty = (count_q != '0);
   assign tx_busy     = (tx_state_q == ST_SEND);

   assign push = rx_valid & ~rx_full;
   assign pop  = rd_data & rx_nonempty;

   assign count_ext = 4'(count_q);

   // Status is built from current registered state only, so a read sees
   // the state before any update happening in the same cycle.
   always_comb begin
      status_word      = '0;
      status_word[0]   = rx_nonempty;
      status_word[1]   = tx_busy;
      status_word[2]   = rx_full;
      status_word[3]   = dropped_q;
      status_word[6:4] = count_ext[2:0];
      status_word[8]   = rx_ie_q;
      status_word[9]   = tx_ie_q;
   end

   // Next-state logic
   always_comb begin
      tx_state_d = tx_state_q;
      tx_data_d  = tx_data_q;
      dropped_d  = dropped_q;
      rx_ie_d    = rx_ie_q;
      tx_ie_d    = tx_ie_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      rdata_d    = rdata_q;
      rvalid_d   = rd_data | rd_stat;
      irq_d      = 1'b0;

      // TX: a data write while a word is in flight (handshake cycle
      // included) is discarded and flagged.
      case (tx_state_q)
         ST_IDLE: begin
            if (wr_data) begin
               tx_data_d  = mem_wdata;
               tx_state_d = ST_SEND;
            end
         end
         default: begin
            if (tx_ready)
               tx_state_d = ST_IDLE;
            if (wr_data)
               dropped_d = 1'b1;
         end
      endcase

      if (wr_stat) begin
         rx_ie_d = mem_wdata[8];
         tx_ie_d = mem_wdata[9];
         if (mem_wdata[3])
            dropped_d = 1'b0;
      end

      // RX FIFO bookkeeping; push and pop together leave the count alone.
      if (push)
         wptr_d = wptr_q + PW'(1);
      if (pop)
         rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (rd_data)
         rdata_d = rx_nonempty ? fifo_q[rptr_q] : 32'h0;
      else if (rd_stat)
         rdata_d = status_word;

      irq_d = (rx_ie_d & (count_d != '0)) | (tx_ie_d & (tx_state_d == ST_IDLE));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_data_q  <= '0;
         dropped_q  <= 1'b0;
         rx_ie_q    <= 1'b0;
         tx_ie_q    <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_data_q  <= tx_data_d;
         dropped_q  <= dropped_d;
         rx_ie_q    <= rx_ie_d;
         tx_ie_q    <= tx_ie_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         irq_q      <= irq_d;
      end
   end

   // FIFO storage needs no reset: occupancy is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wptr_q] <= rx_data;
   end

   assign mem_rdata  = rdata_q;
   assign mem_rvalid = rvalid_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_busy;
   assign rx_ready   = ~rx_full;
   assign irq        = irq_q;

endmodule

// File: tb/tb_mmio_device_responder.sv
// Directed self-checking bench for mmio_device_responder (default params).
module tb_mmio_device_responder;

   localparam logic [31:0] DA = 32'hFFFF8004;
   localparam logic [31:0] SA = 32'hFFFF8000;
   localparam logic [31:0] NA = 32'hFFFF8008;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re, mem_rvalid, mem_hit;
   logic [31:0] tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

   int tests = 0;
   int fails = 0;

   mmio_device_responder #(
      .DATA_ADDR  (DA),
      .STATUS_ADDR(SA),
      .RX_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .mem_rvalid(mem_rvalid),
      .mem_hit   (mem_hit),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      mem_addr = a; mem_wdata = d; mem_we = 1'b1;
      tick();
      mem_we = 1'b0;
   endtask

   task automatic cpu_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      mem_addr = a; mem_re = 1'b1;
      tick();
      mem_re = 1'b0;
      chk({tag, "_rvalid"}, {31'b0, mem_rvalid}, 32'd1);
      chk(tag, mem_rdata, exp);
   endtask

   task automatic rx_push(input logic [31:0] d);
      rx_data = d; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      repeat (2) tick();

      // Reset state and address decode
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("rst_tx_data",  tx_data, 32'h0);
      chk("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
      chk("rst_irq",      {31'b0, irq}, 32'd0);
      chk("rst_rdata",    mem_rdata, 32'h0);
      chk("rst_rvalid",   {31'b0, mem_rvalid}, 32'd0);
      mem_addr = DA; #1 chk("hit_data", {31'b0, mem_hit}, 32'd1);
      mem_addr = SA; #1 chk("hit_stat", {31'b0, mem_hit}, 32'd1);
      mem_addr = NA; #1 chk("hit_none", {31'b0, mem_hit}, 32'd0);
      reset = 1'b0;
      tick();

      // Non-hit accesses and write+read together
      cpu_write(NA, 32'h1234);
      chk("nohit_wr_txv", {31'b0, tx_valid}, 32'd0);
      chk("nohit_wr_rv",  {31'b0, mem_rvalid}, 32'd0);
      mem_addr = NA; mem_re = 1'b1; tick(); mem_re = 1'b0;
      chk("nohit_rd_rv",  {31'b0, mem_rvalid}, 32'd0);
      mem_addr = SA; mem_wdata = 32'h0; mem_we = 1'b1; mem_re = 1'b1; tick();
      mem_we = 1'b0; mem_re = 1'b0;
      chk("wr_rd_rv",     {31'b0, mem_rvalid}, 32'd0);
      chk("wr_rd_rdata",  mem_rdata, 32'h0);

      // TX handshake with three stall cycles
      cpu_write(DA, 32'hA5);
      for (int i = 0; i < 3; i++) begin
         chk("tx_hold_valid", {31'b0, tx_valid}, 32'd1);
         chk("tx_hold_data",  tx_data, 32'hA5);
         if (i < 2) tick();
      end
      tx_ready = 1'b1;
      chk("tx_hs_valid", {31'b0, tx_valid}, 32'd1);
      tick();
      tx_ready = 1'b0;
      chk("tx_done_valid", {31'b0, tx_valid}, 32'd0);
      cpu_read("tx_done_stat", SA, 32'h0);

      // Overrun while sending, then sticky clear
      cpu_write(DA, 32'h22);
      cpu_write(DA, 32'h11);
      chk("drop_tx_data", tx_data, 32'h22);
      cpu_read("drop_stat", SA, 32'h0000000A);
      cpu_write(SA, 32'h8);
      cpu_read("clr_stat", SA, 32'h00000002);
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      chk("drop_idle", {31'b0, tx_valid}, 32'd0);

      // Write landing on the handshake cycle is dropped, not queued
      cpu_write(DA, 32'h33);
      tx_ready = 1'b1;
      cpu_write(DA, 32'h44);
      tx_ready = 1'b0;
      chk("hs_drop_valid", {31'b0, tx_valid}, 32'd0);
      chk("hs_drop_data",  tx_data, 32'h33);
      cpu_read("hs_drop_stat", SA, 32'h00000008);
      cpu_write(SA, 32'h8);

      // Fill FIFO; first push coincides with a status read (old state seen)
      rx_data = 32'd1; rx_valid = 1'b1;
      cpu_read("pre_push_stat", SA, 32'h0);
      rx_valid = 1'b0;
      rx_push(32'd2);
      rx_push(32'd3);
      rx_push(32'd4);
      chk("full_rx_ready", {31'b0, rx_ready}, 32'd0);
      rx_push(32'd99);
      cpu_read("full_stat", SA, 32'h00000045);
      cpu_read("pop1", DA, 32'd1);
      cpu_read("pop2", DA, 32'd2);
      cpu_read("pop3", DA, 32'd3);
      cpu_read("pop4", DA, 32'd4);
      cpu_read("pop_empty", DA, 32'd0);
      cpu_read("empty_stat", SA, 32'h0);

      // Simultaneous push and pop (pointers have wrapped by now)
      rx_push(32'd7);
      rx_push(32'd8);
      rx_data = 32'd5; rx_valid = 1'b1;
      cpu_read("pp_pop", DA, 32'd7);
      rx_valid = 1'b0;
      cpu_read("pp_stat", SA, 32'h00000021);
      cpu_read("pp_pop2", DA, 32'd8);
      cpu_read("pp_pop3", DA, 32'd5);

      // Interrupts
      cpu_write(SA, 32'h100);
      chk("irq_rx_idle", {31'b0, irq}, 32'd0);
      rx_push(32'h55);
      chk("irq_rx_set", {31'b0, irq}, 32'd1);
      cpu_read("irq_pop", DA, 32'h55);
      chk("irq_rx_clr", {31'b0, irq}, 32'd0);
      cpu_write(SA, 32'h200);
      chk("irq_tx_idle", {31'b0, irq}, 32'd1);
      cpu_write(DA, 32'h66);
      chk("irq_tx_busy", {31'b0, irq}, 32'd0);
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      chk("irq_tx_done", {31'b0, irq}, 32'd1);
      cpu_write(SA, 32'h0);
      chk("irq_off", {31'b0, irq}, 32'd0);

      // Reset mid-send with three FIFO entries
      cpu_write(SA, 32'h100);
      rx_push(32'hA);
      rx_push(32'hB);
      rx_push(32'hC);
      cpu_write(DA, 32'h77);
      cpu_read("pre_rst_stat", SA, 32'h00000133);
      chk("pre_rst_irq", {31'b0, irq}, 32'd1);
      reset = 1'b1;
      #1;
      chk("arst_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("arst_tx_data",  tx_data, 32'h0);
      chk("arst_rx_ready", {31'b0, rx_ready}, 32'd1);
      chk("arst_irq",      {31'b0, irq}, 32'd0);
      chk("arst_rdata",    mem_rdata, 32'h0);
      chk("arst_rvalid",   {31'b0, mem_rvalid}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      cpu_read("post_rst_stat", SA, 32'h0);
      cpu_read("post_rst_pop", DA, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
